ring_router_bd: RTL

- Single ring-NoC node for the ring top level, replacing the fixed-format router.
- Parametrised field widths, buffer depth and on/off threshold; selectable unidirectional or bidirectional shortest-path mode.
- Per-input FIFOs with registered on/off backpressure, round-robin arbitration between through traffic and local injection, and a single local eject port.
- NUM_NODES instances are chained east/west by the ring top.

---
 rtl/ring_pkg.sv | 54 +++++
 rtl/ring_fifo.sv | 56 +++++
 rtl/ring_router_bd.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring NoC node.
// Packet layout, MSB to LSB: {valid, ts[TS_W], src[ID_W], dst[ID_W]}.
// Offsets are functions of the field widths so every instance can size its own packet.
package ring_pkg;

  typedef enum logic {
    DIR_EAST = 1'b0,
    DIR_WEST = 1'b1
  } ring_dir_e;

  // Widest packet the pack helper can build; callers truncate to their PKT_W.
  localparam int unsigned PKT_MAX_W = 256;

  function automatic int unsigned dst_lsb();
    return 0;
  endfunction

  function automatic int unsigned src_lsb(input int unsigned id_w);
    return id_w;
  endfunction

  function automatic int unsigned ts_lsb(input int unsigned id_w);
    return 2 * id_w;
  endfunction

  function automatic int unsigned valid_bit(input int unsigned id_w, input int unsigned ts_w);
    return 2 * id_w + ts_w;
  endfunction

  // Hop distance travelling east from src to dst on an n-node ring.
  function automatic int unsigned ring_dist(input int unsigned src, input int unsigned dst,
                                            input int unsigned n);
    return ((dst % n) + n - (src % n)) % n;
  endfunction

  // Builds a valid packet; fields are masked to their widths.
  function automatic logic [PKT_MAX_W-1:0] pkt_pack(input logic [63:0] ts,
                                                    input logic [63:0] src,
                                                    input logic [63:0] dst,
                                                    input int unsigned id_w,
                                                    input int unsigned ts_w);
    logic [PKT_MAX_W-1:0] id_mask;
    logic [PKT_MAX_W-1:0] ts_mask;
    logic [PKT_MAX_W-1:0] p;
    id_mask = (PKT_MAX_W'(1) << id_w) - PKT_MAX_W'(1);
    ts_mask = (PKT_MAX_W'(1) << ts_w) - PKT_MAX_W'(1);
    p = (PKT_MAX_W'(dst) & id_mask) << dst_lsb();
    p |= (PKT_MAX_W'(src) & id_mask) << src_lsb(id_w);
    p |= (PKT_MAX_W'(ts) & ts_mask) << ts_lsb(id_w);
    p |= PKT_MAX_W'(1) << valid_bit(id_w, ts_w);
    return p;
  endfunction

endpackage

// File: rtl/ring_fifo.sv
// Synchronous FIFO with combinational head read.
// Ports: push/din write, pop/dout read head, count/full/empty status.
// A push while full is accepted only when a pop frees a slot in the same cycle;
// a pop while empty is ignored.
module ring_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/ring_router_bd.sv
// Single ring-NoC node: per-input FIFOs, registered on/off backpressure,
// round-robin arbitration of through traffic vs local injection per direction,
// and one local eject port.
// Ports: clk/rst_n; clk_counter timestamp; inject_valid/inject_dst/inject_ready
// local injection; link_{west,east}_in/out ring links; stop_*_rd neighbour stops,
// stop_*_wr our stops; eject_valid/eject_pkt delivery; overflow sticky drop flag;
// total_* statistics.
// Optional macro RING_ROUTER_STATS_EN builds the 64-bit statistics counters;
// without it the three statistics outputs are tied to zero.
module ring_router_bd
  import ring_pkg::*;
#(
  parameter int unsigned NUM_NODES   = 4,
  parameter int unsigned ROUTER_ID   = 0,
  parameter int unsigned ID_W        = 16,
  parameter int unsigned TS_W        = 16,
  parameter int unsigned PKT_W       = 1 + TS_W + 2 * ID_W,
  parameter int unsigned BUFFER_SIZE = 4,
  parameter int unsigned OFF_SLACK   = 2,
  parameter int unsigned BIDIR       = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [TS_W-1:0]  clk_counter,
  input  logic             inject_valid,
  input  logic [ID_W-1:0]  inject_dst,
  output logic             inject_ready,
  input  logic [PKT_W-1:0] link_west_in,
  input  logic [PKT_W-1:0] link_east_in,
  output logic [PKT_W-1:0] link_east_out,
  output logic [PKT_W-1:0] link_west_out,
  input  logic             stop_east_rd,
  input  logic             stop_west_rd,
  output logic             stop_east_wr,
  output logic             stop_west_wr,
  output logic             eject_valid,
  output logic [PKT_W-1:0] eject_pkt,
  output logic             overflow,
  output logic [63:0]      total_packet_sent,
  output logic [63:0]      total_packet_recieve,
  output logic [63:0]      total_latency
);

  localparam int unsigned VALID_BIT = valid_bit(ID_W, TS_W);
  localparam int unsigned CNT_W     = $clog2(BUFFER_SIZE + 1);

  logic [PKT_W-1:0] w_head, e_head, inj_pkt, ej_head;
  logic [CNT_W-1:0] w_count, e_count, w_cnt_nxt, e_cnt_nxt;
  logic             w_full, w_empty, e_full, e_empty;
  logic             w_push, e_push, w_pop, e_pop, w_acc, e_acc;
  logic             w_stop_nxt, e_stop_nxt, ovf_hit;
  logic             w_eject, e_eject, w_fwd, e_fwd;
  logic             inj_self, inj_east, inj_west;
  int unsigned      inj_dist;
  ring_dir_e        inj_dir;
  logic             gnt_thru_e, gnt_inj_e, gnt_thru_w, gnt_inj_w;
  logic             gnt_ej_w, gnt_ej_e, ej_any;
  logic             favour_inj_e, favour_inj_w;
  ring_dir_e        ej_favour;

  // FIFO_W holds eastbound traffic from the west link, FIFO_E westbound from the east link.
  ring_fifo #(.WIDTH(PKT_W), .DEPTH(BUFFER_SIZE)) u_fifo_w (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (link_west_in),
    .dout  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  ring_fifo #(.WIDTH(PKT_W), .DEPTH(BUFFER_SIZE)) u_fifo_e (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (e_push),
    .pop   (e_pop),
    .din   (link_east_in),
    .dout  (e_head),
    .count (e_count),
    .full  (e_full),
    .empty (e_empty)
  );

  assign w_push = link_west_in[VALID_BIT];
  assign e_push = link_east_in[VALID_BIT];

  // Head routing: local destination ejects, anything else keeps its travel direction.
  assign w_eject = !w_empty && (w_head[ID_W-1:0] == ID_W'(ROUTER_ID));
  assign e_eject = !e_empty && (e_head[ID_W-1:0] == ID_W'(ROUTER_ID));
  assign w_fwd   = !w_empty && !w_eject;
  assign e_fwd   = !e_empty && !e_eject;

  // Injection direction: shortest path, ties travel east.
  assign inj_self = (inject_dst == ID_W'(ROUTER_ID));
  assign inj_dist = ring_dist(ROUTER_ID, 32'(inject_dst), NUM_NODES);
  assign inj_dir  = ((BIDIR != 0) && (inj_dist > NUM_NODES / 2)) ? DIR_WEST : DIR_EAST;
  assign inj_east = inject_valid && !inj_self && (inj_dir == DIR_EAST);
  assign inj_west = inject_valid && !inj_self && (inj_dir == DIR_WEST);
  assign inj_pkt  = PKT_W'(pkt_pack(64'(clk_counter), 64'(ROUTER_ID), 64'(inject_dst),
                                    ID_W, TS_W));

  // Per-direction output arbitration and eject arbitration.
  always_comb begin
    gnt_thru_e = 1'b0;
    gnt_inj_e  = 1'b0;
    gnt_thru_w = 1'b0;
    gnt_inj_w  = 1'b0;
    gnt_ej_w   = 1'b0;
    gnt_ej_e   = 1'b0;
    if (!stop_east_rd) begin
      if (w_fwd && inj_east) begin
        if (favour_inj_e) gnt_inj_e  = 1'b1;
        else              gnt_thru_e = 1'b1;
      end else begin
        gnt_thru_e = w_fwd;
        gnt_inj_e  = inj_east;
      end
    end
    if (!stop_west_rd) begin
      if (e_fwd && inj_west) begin
        if (favour_inj_w) gnt_inj_w  = 1'b1;
        else              gnt_thru_w = 1'b1;
      end else begin
        gnt_thru_w = e_fwd;
        gnt_inj_w  = inj_west;
      end
    end
    if (w_eject && e_eject) begin
      if (ej_favour == DIR_WEST) gnt_ej_e = 1'b1;
      else                       gnt_ej_w = 1'b1;
    end else begin
      gnt_ej_w = w_eject;
      gnt_ej_e = e_eject;
    end
  end

  assign ej_any  = gnt_ej_w || gnt_ej_e;
  assign ej_head = gnt_ej_e ? e_head : w_head;
  assign w_pop   = gnt_thru_e || gnt_ej_w;
  assign e_pop   = gnt_thru_w || gnt_ej_e;

  // Self-destined requests are acknowledged and dropped so the source never stalls.
  assign inject_ready = gnt_inj_e || gnt_inj_w || (inject_valid && inj_self);

  // Occupancy after this cycle's push/pop drives the registered stop.
  assign w_acc      = w_push && (!w_full || w_pop);
  assign e_acc      = e_push && (!e_full || e_pop);
  assign w_cnt_nxt  = w_count + CNT_W'(w_acc) - CNT_W'(w_pop);
  assign e_cnt_nxt  = e_count + CNT_W'(e_acc) - CNT_W'(e_pop);
  assign w_stop_nxt = (BUFFER_SIZE - 32'(w_cnt_nxt)) <= OFF_SLACK;
  assign e_stop_nxt = (BUFFER_SIZE - 32'(e_cnt_nxt)) <= OFF_SLACK;
  assign ovf_hit    = (w_push && w_full && !w_pop) || (e_push && e_full && !e_pop);

  // Output registers, stops, sticky overflow and round-robin pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_east_out <= '0;
      link_west_out <= '0;
      eject_valid   <= 1'b0;
      eject_pkt     <= '0;
      stop_east_wr  <= 1'b0;
      stop_west_wr  <= 1'b0;
      overflow      <= 1'b0;
      favour_inj_e  <= 1'b0;
      favour_inj_w  <= 1'b0;
      ej_favour     <= DIR_EAST;
    end else begin
      link_east_out <= gnt_thru_e ? w_head : (gnt_inj_e ? inj_pkt : '0);
      link_west_out <= gnt_thru_w ? e_head : (gnt_inj_w ? inj_pkt : '0);
      eject_valid   <= ej_any;
      eject_pkt     <= ej_any ? ej_head : '0;
      stop_west_wr  <= w_stop_nxt;
      stop_east_wr  <= e_stop_nxt;
      if (ovf_hit) overflow <= 1'b1;
      if (gnt_thru_e)     favour_inj_e <= 1'b1;
      else if (gnt_inj_e) favour_inj_e <= 1'b0;
      if (gnt_thru_w)     favour_inj_w <= 1'b1;
      else if (gnt_inj_w) favour_inj_w <= 1'b0;
      if (gnt_ej_w)       ej_favour <= DIR_WEST;
      else if (gnt_ej_e)  ej_favour <= DIR_EAST;
    end
  end

`ifdef RING_ROUTER_STATS_EN
  localparam int unsigned TS_LSB = ts_lsb(ID_W);
  logic [TS_W-1:0] ej_ts;

  assign ej_ts = ej_head[TS_LSB +: TS_W];

  // Injection/eject counts and summed timestamp latency, all wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_packet_sent    <= '0;
      total_packet_recieve <= '0;
      total_latency        <= '0;
    end else begin
      if (gnt_inj_e || gnt_inj_w) total_packet_sent <= total_packet_sent + 64'd1;
      if (ej_any) begin
        total_packet_recieve <= total_packet_recieve + 64'd1;
        total_latency        <= total_latency + 64'(TS_W'(clk_counter - ej_ts));
      end
    end
  end
`else
  assign total_packet_sent    = '0;
  assign total_packet_recieve = '0;
  assign total_latency        = '0;
`endif

  // Local traffic must never target this node.
  inj_not_self : assert property (@(posedge clk) disable iff (!rst_n)
                                  !(inject_valid && inj_self));

endmodule
